// File: rtl/shift_norm.sv
// shift_norm: multi-cycle leading-zero / redundant-sign normalizer using a 16-8-4-2-1 binary search
module shift_norm (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        al,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [5:0]  cnt,
    output logic [31:0] norm,
    output logic        zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      r_state, w_next;
    logic [2:0]  r_s;
    logic [31:0] r_w;
    logic [5:0]  r_cnt;
    logic        r_al, r_sg, r_zero;
    logic        w_accept, w_hit;
    logic [5:0]  w_k;
    logic [31:0] w_mask_u, w_mask_s;
    // Step distance, top-bit masks and whether the current step may shift.
    always_comb begin
        w_accept = start && (r_state != RUN);
        w_k      = 6'd16 >> r_s;
        w_mask_u = ~(32'hFFFF_FFFF >> w_k);
        w_mask_s = ~(32'hFFFF_FFFF >> (w_k + 6'd1));
        w_hit    = r_al ? (((r_w ^ {32{r_sg}}) & w_mask_s) == 32'd0)
                        : ((r_w & w_mask_u) == 32'd0);
        w_next   = w_accept ? RUN
                 : (r_state == RUN) ? ((r_s == 3'd4) ? DONE : RUN)
                 : IDLE;
    end
    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // Load operand on an accepted start, then apply one search step per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= 3'd0;
            r_w    <= 32'd0;
            r_cnt  <= 6'd0;
            r_al   <= 1'b0;
            r_sg   <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_s    <= 3'd0;
            r_w    <= a;
            r_cnt  <= 6'd0;
            r_al   <= al;
            r_sg   <= a[31];
            r_zero <= al ? ((a == 32'd0) || (a == 32'hFFFF_FFFF)) : (a == 32'd0);
        end else if (r_state == RUN) begin
            r_s <= r_s + 3'd1;
            if (r_s == 3'd4 && !r_al && r_zero) begin
                r_cnt <= 6'd32;
                r_w   <= 32'd0;
            end else if (w_hit) begin
                r_w   <= r_w << w_k;
                r_cnt <= r_cnt + w_k;
            end
        end
    end
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign cnt  = r_cnt;
    assign norm = r_w;
    assign zero = r_zero;
endmodule

// File: tb/tb_shift_norm.sv
// tb_shift_norm: directed and random checks of shift_norm against a leading-count reference model
module tb_shift_norm;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, al = 1'b0;
    logic [31:0] a = 32'd0;
    logic        busy, done, zero;
    logic [5:0]  cnt;
    logic [31:0] norm;
    int n_chk = 0, n_err = 0;
    int cyc = 0, m_c0 = -100;
    logic [5:0]  e_cnt = 6'd0;
    logic [31:0] e_norm = 32'd0;
    logic        e_zero = 1'b0;

    shift_norm dut (
        .clk(clk), .rst(rst), .start(start), .al(al), .a(a),
        .busy(busy), .done(done), .cnt(cnt), .norm(norm), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic void ref_model(input logic [31:0] x, input logic m,
                                      output logic [5:0] c, output logic [31:0] n, output logic z);
        int k = 0;
        if (!m) begin
            z = (x == 32'd0);
            while (k < 32 && !x[31-k]) k++;
        end else begin
            z = (x == 32'd0) || (x == 32'hFFFF_FFFF);
            while (k < 31 && x[30-k] == x[31]) k++;
        end
        c = 6'(k);
        n = (k >= 32) ? 32'd0 : (x << k);
    endfunction

    // Reference: an operation accepted at cycle m_c0 is busy for 5 cycles, done on the 6th.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_c0 = -100; e_cnt = 6'd0; e_norm = 32'd0; e_zero = 1'b0;
        end else if (start && !((cyc - 1 - m_c0) >= 0 && (cyc - 1 - m_c0) <= 4)) begin
            m_c0 = cyc;
            ref_model(a, al, e_cnt, e_norm, e_zero);
        end
    end

    // Compare DUT against the reference every cycle.
    always @(negedge clk) begin
        int dd;
        dd = cyc - m_c0;
        chk("busy", 32'(busy), 32'(dd >= 0 && dd <= 4));
        chk("done", 32'(done), 32'(dd == 5));
        if (!(dd >= 0 && dd <= 4)) begin
            chk("cnt", 32'(cnt), 32'(e_cnt));
            chk("norm", norm, e_norm);
            chk("zero", 32'(zero), 32'(e_zero));
        end
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin lat = i; return; end
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic m, input logic lit,
                          input logic [5:0] lc, input logic [31:0] ln, input logic lz);
        int lat;
        logic [5:0] mc; logic [31:0] mn; logic mz;
        @(negedge clk);
        a = x; al = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("latency", 32'(lat + 1), 32'd6);
        if (lat > 0) chk("norm_is_shift", norm, (cnt >= 6'd32) ? 32'd0 : (x << cnt));
        if (lit) begin
            chk("lit_cnt", 32'(cnt), 32'(lc));
            chk("lit_norm", norm, ln);
            chk("lit_zero", 32'(zero), 32'(lz));
            ref_model(x, m, mc, mn, mz);
            chk("model_cnt", 32'(mc), 32'(lc));
            chk("model_norm", mn, ln);
        end
    endtask

    initial begin
        int nd, p0, p1, lat;
        logic [31:0] x;
        logic m;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_norm", norm, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h0001_0000, 1'b0, 1'b1, 6'd15, 32'h8000_0000, 1'b0);
        run_op(32'h8000_0000, 1'b0, 1'b1, 6'd0,  32'h8000_0000, 1'b0);
        run_op(32'h0000_0000, 1'b0, 1'b1, 6'd32, 32'h0000_0000, 1'b1);
        run_op(32'h0000_0001, 1'b0, 1'b1, 6'd31, 32'h8000_0000, 1'b0);
        run_op(32'hFFFF_8000, 1'b1, 1'b1, 6'd16, 32'h8000_0000, 1'b0);
        run_op(32'h0000_0001, 1'b1, 1'b1, 6'd30, 32'h4000_0000, 1'b0);
        run_op(32'hFFFF_FFFF, 1'b1, 1'b1, 6'd31, 32'h8000_0000, 1'b1);
        run_op(32'h0000_0000, 1'b1, 1'b1, 6'd31, 32'h0000_0000, 1'b1);
        // start held high: two back-to-back results six cycles apart
        @(negedge clk);
        a = 32'h0000_F000; al = 1'b0; start = 1'b1;
        nd = 0; p0 = -1; p1 = -1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("hold_cnt", 32'(cnt), 32'd16);
                if (p0 < 0) p0 = i; else p1 = i;
            end
            if (i == 12) start = 1'b0;
        end
        chk("hold_pulses", 32'(nd), 32'd2);
        chk("hold_gap", 32'(p1 - p0), 32'd6);
        // start during RUN with a different operand is ignored
        @(negedge clk);
        a = 32'h0000_F000; al = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'h0000_0001; al = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ignored_lat", 32'(lat), 32'd3);
        chk("ignored_cnt", 32'(cnt), 32'd16);
        chk("ignored_norm", norm, 32'hF000_0000);
        // reset in the third RUN cycle aborts the operation
        @(negedge clk);
        a = 32'h0000_F000; al = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_cnt", 32'(cnt), 32'd0);
        chk("abort_norm", norm, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        run_op(32'h0000_0100, 1'b0, 1'b1, 6'd23, 32'h8000_0000, 1'b0);
        // random operands spread over all leading counts
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            x = x >> $urandom_range(0, 32);
            m = 1'($urandom_range(0, 1));
            if (m && $urandom_range(0, 1) == 1) x = ~x;
            run_op(x, m, 1'b0, 6'd0, 32'd0, 1'b0);
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/shift_norm.md
# shift_norm

Multi-cycle normalizer for the miniRV datapath: given a 32-bit word, it computes the left-shift amount that normalizes it, and the normalized word. Unsigned mode counts leading zeros. Signed mode counts redundant sign bits. It is the inverse companion of the combinational barrel shifter, recovering `b` such that `a << b` is normalized. A binary search over shift distances 16, 8, 4, 2, 1 runs one step per cycle behind a start/done handshake.

## Interface
- No parameters; data width fixed at 32, count width fixed at 6.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled on rising edge; accepted only in IDLE or DONE.
- `al`  input  1  mode, sampled with accepted `start`: 0 = unsigned leading-zero count, 1 = signed redundant-sign-bit count.
- `a`  input  32  operand, sampled with accepted `start`.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; results valid from this cycle until next accepted `start`.
- `cnt`  output  6  shift amount; unsigned 0..32, signed 0..31.
- `norm`  output  32  `a` shifted left by `cnt`, zero-filled; 0 when unsigned `cnt` = 32.
- `zero`  output  1  unsigned: `a` == 0; signed: `a` == 0x00000000 or 0xFFFFFFFF.

## Operation
- States: IDLE, RUN, DONE. Step index `s` is 3 bits, 0..4; step distance `k` = 16, 8, 4, 2, 1 for `s` = 0..4.
- Accepted `start` in IDLE or DONE:
  - Registers working word `w` = `a`, latched mode, and `cnt` accumulator = 0.
  - Computes `zero` from `a`.
  - Sets `s` = 0 and enters RUN.
- RUN step, unsigned:
  - If `w[31:32-k]` is all zero: `w` <= `w << k` and `cnt` += `k`.
  - Otherwise no change.
- RUN step, signed:
  - Sign bit `sg` = `a[31]` of the latched operand.
  - If `w[31:31-k]` (k+1 bits) all equal `sg`: `w` <= `w << k` and `cnt` += `k`.
  - Otherwise no change.
- `s` increments each RUN cycle. After the `s` = 4 step, go to DONE.
- After the final step, in unsigned mode with `zero` = 1: force `cnt` = 32 and `norm` = 0.
- `norm` is driven from `w`.
- DONE lasts one cycle with `done` = 1, then returns to IDLE. `cnt`, `norm` and `zero` hold in IDLE.
- `start` in RUN is ignored, with no queueing.
- `start` in DONE is accepted; this gives back-to-back operation with no idle cycle.
- Arithmetic: the `cnt` accumulator is 6 bits.
  - Signed maximum is 31, reached for 0 and -1. Signed `norm` is then 0x00000000 or 0x80000000 respectively.
  - Unsigned maximum from the search is 31; the zero override supplies 32.

## Timing
- Reset (async, immediate) values:
  - State IDLE, `busy` = 0, `done` = 0.
  - `cnt` = 0, `norm` = 0, `zero` = 0, `s` = 0.
- Latency: `start` sampled at edge E0; RUN steps at edges E1..E5; `done` high in the cycle following E5. Start to done is 6 cycles.
- Throughput: one operation per 6 cycles when `start` is held or re-asserted during DONE.
- `busy` is high in the cycles after E0 through E4, and low in the DONE cycle.
- Reset mid-RUN aborts the operation: no `done` pulse, and all outputs return to reset values.
- `cnt` and `norm` are intermediate during RUN. They are valid only from `done` onward.

## Test plan
- Unsigned, `a` = 0x00010000 -> `done` 6 cycles after start; `cnt` = 15, `norm` = 0x80000000, `zero` = 0. `a` = 0x80000000 -> `cnt` = 0, `norm` = 0x80000000.
- Unsigned, `a` = 0 -> `cnt` = 32, `norm` = 0, `zero` = 1. `a` = 1 -> `cnt` = 31, `norm` = 0x80000000.
- Signed, `a` = 0xFFFF8000 -> `cnt` = 16, `norm` = 0x80000000. `a` = 0x00000001 -> `cnt` = 30, `norm` = 0x40000000. `a` = 0xFFFFFFFF -> `cnt` = 31, `norm` = 0x80000000, `zero` = 1.
- Handshake:
  - Assert `start` with `a` = 0x0000F000 and hold it high for 12 cycles.
  - Expect two results (`cnt` = 16 each) with `done` pulses 6 cycles apart.
  - A second `start` pulse during RUN with different `a` is ignored.
- Reset mid-operation:
  - Assert `rst` in the 3rd RUN cycle.
  - Expect `busy`, `done`, `cnt` and `norm` at 0 immediately with no `done` pulse.
  - A subsequent start with `a` = 0x00000100 gives `cnt` = 23.
- Randomized: 1000 random `a` and `al` values compared against a reference leading-zero / leading-sign count model. `norm` must equal `a << cnt`.
